// File: rtl/regfile_arbiter.sv
// Two-requester round-robin arbiter in front of a 4x5 register set: IDLE -> ACCESS -> RESP.
// Optional write-to-read forwarding is enabled by defining REGFILE_ARBITER_BYPASS_EN.
module regfile_arbiter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic       req1,
  input  logic       we0,
  input  logic       we1,
  input  logic [1:0] ra0,
  input  logic [1:0] rb0,
  input  logic [1:0] ra1,
  input  logic [1:0] rb1,
  input  logic [1:0] wr0,
  input  logic [1:0] wr1,
  input  logic [4:0] wrd0,
  input  logic [4:0] wrd1,
  output logic       ack0,
  output logic       ack1,
  output logic [4:0] rd_a,
  output logic [4:0] rd_b,
  output logic       busy,
  output logic [1:0] Ra,
  output logic [1:0] Rb,
  output logic [1:0] Wr,
  output logic [4:0] Wrd,
  output logic       reg_en,
  input  logic [4:0] a,
  input  logic [4:0] b
);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  typedef struct packed {
    logic       we;
    logic [1:0] ra;
    logic [1:0] rb;
    logic [1:0] wr;
    logic [4:0] wrd;
  } req_t;

  state_t     state, state_nxt;
  req_t [1:0] req_in;
  req_t       cur;
  logic       owner;
  logic       last;
  logic       any_req;
  logic       gnt_id;
  logic       take;
  logic [4:0] fwd_a, fwd_b;

  assign req_in[0] = {we0, ra0, rb0, wr0, wrd0};
  assign req_in[1] = {we1, ra1, rb1, wr1, wrd1};
  assign any_req   = req0 | req1;

  // Requester 0 wins if it is alone, or on a tie when 1 was granted last.
  assign gnt_id = (req0 && (!req1 || last)) ? 1'b0 : 1'b1;
  assign take   = (state == IDLE) && any_req;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (any_req) state_nxt = ACCESS;
      ACCESS:  state_nxt = RESP;
      RESP:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Winner fields are frozen at grant so requester changes mid-transaction are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur   <= '0;
      owner <= 1'b0;
      last  <= 1'b1;
    end else if (take) begin
      cur   <= req_in[gnt_id];
      owner <= gnt_id;
      last  <= gnt_id;
    end
  end

`ifdef REGFILE_ARBITER_BYPASS_EN
  assign fwd_a = (cur.we && (cur.ra == cur.wr)) ? cur.wrd : a;
  assign fwd_b = (cur.we && (cur.rb == cur.wr)) ? cur.wrd : b;
`else
  assign fwd_a = a;
  assign fwd_b = b;
`endif

  // Read data is sampled on the same edge the write commits, so a/b are pre-write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_a <= '0;
      rd_b <= '0;
    end else if (state == ACCESS) begin
      rd_a <= fwd_a;
      rd_b <= fwd_b;
    end
  end

  assign busy   = (state != IDLE);
  assign reg_en = (state == ACCESS) && cur.we;
  assign ack0   = (state == RESP) && !owner;
  assign ack1   = (state == RESP) && owner;
  assign Ra     = cur.ra;
  assign Rb     = cur.rb;
  assign Wr     = cur.wr;
  assign Wrd    = cur.wrd;

endmodule

// File: tb/tb_regfile_arbiter.sv
// Self-checking bench for regfile_arbiter: behavioural register set plus a read-data scoreboard.
module tb_regfile_arbiter;

`ifdef REGFILE_ARBITER_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req0 = 0, req1 = 0, we0 = 0, we1 = 0;
  logic [1:0] ra0 = 0, rb0 = 0, ra1 = 0, rb1 = 0, wr0 = 0, wr1 = 0;
  logic [4:0] wrd0 = 0, wrd1 = 0;
  logic       ack0, ack1, busy, reg_en;
  logic [4:0] rd_a, rd_b, Wrd, a, b;
  logic [1:0] Ra, Rb, Wr;

  always #5 clk = ~clk;

  regfile_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .req1(req1), .we0(we0), .we1(we1),
    .ra0(ra0), .rb0(rb0), .ra1(ra1), .rb1(rb1),
    .wr0(wr0), .wr1(wr1), .wrd0(wrd0), .wrd1(wrd1),
    .ack0(ack0), .ack1(ack1), .rd_a(rd_a), .rd_b(rd_b), .busy(busy),
    .Ra(Ra), .Rb(Rb), .Wr(Wr), .Wrd(Wrd), .reg_en(reg_en),
    .a(a), .b(b)
  );

  // External register set; not reset, so contents survive arbiter resets.
  logic [4:0] rf [4] = '{default: 5'd0};
  always @(posedge clk) if (reg_en) rf[Wr] <= Wrd;
  assign a = rf[Ra];
  assign b = rf[Rb];

  typedef struct {
    logic       id;
    logic [4:0] ea;
    logic [4:0] eb;
  } exp_t;

  exp_t       sbq[$];
  logic [4:0] sh [4] = '{default: 5'd0};
  int         checks = 0;
  int         errors = 0;

  always @(negedge clk) begin
    if (ack0 || ack1) begin
      exp_t e;
      checks++;
      if (ack0 && ack1) begin
        errors++;
        $display("FAIL ack_onehot: ack0=%0b ack1=%0b, required only one", ack0, ack1);
      end else if (sbq.size() == 0) begin
        errors++;
        $display("FAIL unexpected_ack: ack1=%0b rd_a=%h rd_b=%h, required no ack", ack1, rd_a, rd_b);
      end else begin
        e = sbq.pop_front();
        if ({ack1, rd_a, rd_b} !== {e.id, e.ea, e.eb}) begin
          errors++;
          $display("FAIL scoreboard: got id=%0b rd_a=%h rd_b=%h, required id=%0b rd_a=%h rd_b=%h",
                   ack1, rd_a, rd_b, e.id, e.ea, e.eb);
        end
      end
    end
  end

  task automatic push_exp(input bit id, input bit we, input logic [1:0] wr, input logic [4:0] wrd,
                          input logic [1:0] ra, input logic [1:0] rb);
    exp_t e;
    e.id = id;
    e.ea = (BYP && we && ra == wr) ? wrd : sh[ra];
    e.eb = (BYP && we && rb == wr) ? wrd : sh[rb];
    sbq.push_back(e);
    if (we) sh[wr] = wrd;
  endtask

  task automatic set_fields(input bit id, input bit we, input logic [1:0] wr, input logic [4:0] wrd,
                            input logic [1:0] ra, input logic [1:0] rb);
    if (id) begin we1 = we; wr1 = wr; wrd1 = wrd; ra1 = ra; rb1 = rb; end
    else    begin we0 = we; wr0 = wr; wrd0 = wrd; ra0 = ra; rb0 = rb; end
  endtask

  task automatic issue(input bit id, input bit we, input logic [1:0] wr, input logic [4:0] wrd,
                       input logic [1:0] ra, input logic [1:0] rb,
                       output logic [4:0] got_a, output logic [4:0] got_b);
    bit seen = 0;
    push_exp(id, we, wr, wrd, ra, rb);
    set_fields(id, we, wr, wrd, ra, rb);
    if (id) req1 = 1; else req0 = 1;
    for (int i = 0; i < 12 && !seen; i++) begin
      @(negedge clk);
      seen = id ? ack1 : ack0;
    end
    got_a = rd_a;
    got_b = rd_b;
    if (id) req1 = 0; else req0 = 0;
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL ack_timeout: requester %0d got no ack within 12 cycles, required ack", id);
    end
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({ack0, ack1, busy, reg_en} !== 4'b0) begin
      errors++;
      $display("FAIL reset_ctrl: ack0/ack1/busy/reg_en=%b, required 0000", {ack0, ack1, busy, reg_en});
    end
    checks++;
    if ({rd_a, rd_b} !== 10'd0) begin
      errors++;
      $display("FAIL reset_rd: rd_a=%h rd_b=%h, required 0 0", rd_a, rd_b);
    end
    checks++;
    if ({Ra, Rb, Wr, Wrd} !== 11'd0) begin
      errors++;
      $display("FAIL reset_bus: Ra=%0d Rb=%0d Wr=%0d Wrd=%h, required all 0", Ra, Rb, Wr, Wrd);
    end
    rst_n = 1;
  endtask

  task automatic test_write();
    push_exp(0, 1, 2'd2, 5'h15, 2'd0, 2'd0);
    set_fields(0, 1, 2'd2, 5'h15, 2'd0, 2'd0);
    req0 = 1;
    @(negedge clk);
    checks++;
    if ({reg_en, busy, ack0, Wr, Wrd} !== {1'b1, 1'b1, 1'b0, 2'd2, 5'h15}) begin
      errors++;
      $display("FAIL write_access: reg_en=%0b busy=%0b ack0=%0b Wr=%0d Wrd=%h, required 1 1 0 2 15",
               reg_en, busy, ack0, Wr, Wrd);
    end
    @(negedge clk);
    checks++;
    if ({ack0, ack1, reg_en} !== 3'b100) begin
      errors++;
      $display("FAIL write_resp: ack0=%0b ack1=%0b reg_en=%0b, required 1 0 0", ack0, ack1, reg_en);
    end
    req0 = 0;
    @(negedge clk);
    checks++;
    if ({ack0, ack1, busy} !== 3'b000) begin
      errors++;
      $display("FAIL write_idle: ack0=%0b ack1=%0b busy=%0b, required 0 0 0", ack0, ack1, busy);
    end
    checks++;
    if (rf[2] !== 5'h15) begin
      errors++;
      $display("FAIL write_commit: R2=%h, required 15", rf[2]);
    end
  endtask

  task automatic test_round_robin();
    int         n = 0;
    logic [3:0] ids = '0;
    int         cyc [4] = '{default: 0};
    apply_reset();
    for (int k = 0; k < 4; k++)
      push_exp(k[0], 0, 2'd0, 5'd0, k[0] ? 2'd0 : 2'd2, k[0] ? 2'd2 : 2'd0);
    set_fields(0, 0, 2'd0, 5'd0, 2'd2, 2'd0);
    set_fields(1, 0, 2'd0, 5'd0, 2'd0, 2'd2);
    req0 = 1;
    req1 = 1;
    for (int t = 1; t <= 40 && n < 4; t++) begin
      @(negedge clk);
      if (ack0 || ack1) begin
        ids[n] = ack1;
        cyc[n] = t;
        n++;
      end
    end
    req0 = 0;
    req1 = 0;
    checks++;
    if (n != 4 || ids !== 4'b1010) begin
      errors++;
      $display("FAIL rr_order: %0d acks, order(bit0 first)=%b, required 4 acks order 1010", n, ids);
    end
    checks++;
    if (cyc[0] != 2 || cyc[1] - cyc[0] != 3 || cyc[2] - cyc[1] != 3 || cyc[3] - cyc[2] != 3) begin
      errors++;
      $display("FAIL rr_timing: ack cycles %0d %0d %0d %0d, required 2 5 8 11",
               cyc[0], cyc[1], cyc[2], cyc[3]);
    end
  endtask

  task automatic test_read();
    logic [4:0] ga, gb;
    issue(1, 1, 2'd1, 5'h0A, 2'd0, 2'd0, ga, gb);
    issue(1, 1, 2'd3, 5'h1F, 2'd0, 2'd0, ga, gb);
    issue(1, 0, 2'd0, 5'd0, 2'd1, 2'd3, ga, gb);
    checks++;
    if ({ga, gb} !== {5'h0A, 5'h1F}) begin
      errors++;
      $display("FAIL read_data: rd_a=%h rd_b=%h, required 0a 1f", ga, gb);
    end
  endtask

  task automatic test_bypass();
    logic [4:0] ga, gb;
    logic [4:0] want;
    want = BYP ? 5'h07 : 5'h0A;
    issue(0, 1, 2'd1, 5'h07, 2'd1, 2'd3, ga, gb);
    checks++;
    if ({ga, gb} !== {want, 5'h1F}) begin
      errors++;
      $display("FAIL bypass_rd: rd_a=%h rd_b=%h, required %h 1f", ga, gb, want);
    end
    @(negedge clk);
    checks++;
    if (rf[1] !== 5'h07) begin
      errors++;
      $display("FAIL bypass_commit: R1=%h, required 07", rf[1]);
    end
    issue(1, 0, 2'd0, 5'd0, 2'd1, 2'd1, ga, gb);
    checks++;
    if ({ga, gb} !== {5'h07, 5'h07}) begin
      errors++;
      $display("FAIL bypass_readback: rd_a=%h rd_b=%h, required 07 07", ga, gb);
    end
  endtask

  task automatic test_reset_access();
    @(negedge clk);
    set_fields(0, 1, 2'd2, 5'h03, 2'd0, 2'd0);
    req0 = 1;
    @(negedge clk);
    checks++;
    if (reg_en !== 1'b1) begin
      errors++;
      $display("FAIL abort_pre: reg_en=%0b, required 1", reg_en);
    end
    rst_n = 0;
    #1;
    checks++;
    if ({reg_en, busy, ack0, ack1} !== 4'b0) begin
      errors++;
      $display("FAIL abort_async: reg_en/busy/ack0/ack1=%b, required 0000", {reg_en, busy, ack0, ack1});
    end
    req0 = 0;
    repeat (2) @(negedge clk);
    rst_n = 1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if ({ack0, ack1, busy} !== 3'b000) begin
        errors++;
        $display("FAIL abort_after: cycle %0d ack0=%0b ack1=%0b busy=%0b, required 0 0 0",
                 i, ack0, ack1, busy);
      end
    end
    checks++;
    if (rf[2] !== 5'h15) begin
      errors++;
      $display("FAIL abort_reg: R2=%h, required 15", rf[2]);
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_round_robin();
    test_read();
    test_bypass();
    test_reset_access();
    checks++;
    if (sbq.size() != 0) begin
      errors++;
      $display("FAIL pending_exp: %0d expected responses never arrived, required 0", sbq.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
